// File: rtl/axi_lite_master_bridge.sv
// Core request port to single-beat AXI-lite master bridge.
// Handles one outstanding read or write at a time and pulses valid_o on completion.
module axi_lite_master_bridge #(
  parameter int unsigned C_M_AXI_DATA_WIDTH = 64,
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 64
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     address_i,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     indata_i,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   mask_i,
  input  logic                              ren_i,
  input  logic                              wen_i,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     outdata_o,
  output logic [1:0]                        resp_o,
  output logic                              valid_o,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     aw_addr,
  output logic                              aw_valid,
  input  logic                              aw_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     w_data,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   w_strb,
  output logic                              w_valid,
  input  logic                              w_ready,
  input  logic [1:0]                        b_resp,
  input  logic                              b_valid,
  output logic                              b_ready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     ar_addr,
  output logic                              ar_valid,
  input  logic                              ar_ready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     r_data,
  input  logic [1:0]                        r_resp,
  input  logic                              r_valid,
  output logic                              r_ready
);

  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned SW = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   strb_q, strb_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      resp_q, resp_d;
  logic            aw_valid_q, aw_valid_d;
  logic            w_valid_q, w_valid_d;
  logic            b_ready_q, b_ready_d;
  logic            ar_valid_q, ar_valid_d;
  logic            r_ready_q, r_ready_d;
  logic            valid_q, valid_d;
  logic            aw_done_c, w_done_c;

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done_c = !aw_valid_q || aw_ready;
  assign w_done_c  = !w_valid_q || w_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    rdata_d    = rdata_q;
    resp_d     = resp_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    valid_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (wen_i) begin
          addr_d     = address_i;
          wdata_d    = indata_i;
          strb_d     = mask_i;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          state_d    = WADDR;
        end else if (ren_i) begin
          addr_d     = address_i;
          ar_valid_d = 1'b1;
          state_d    = RADDR;
        end
      end
      WADDR: begin
        if (aw_valid_q && aw_ready) aw_valid_d = 1'b0;
        if (w_valid_q && w_ready)   w_valid_d  = 1'b0;
        if (aw_done_c && w_done_c) begin
          b_ready_d = 1'b1;
          state_d   = WRESP;
        end
      end
      WRESP: begin
        if (b_valid) begin
          resp_d    = b_resp;
          b_ready_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = DONE;
        end
      end
      RADDR: begin
        if (ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = RDATA;
        end
      end
      RDATA: begin
        if (r_valid) begin
          rdata_d   = r_data;
          resp_d    = r_resp;
          r_ready_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      rdata_q    <= '0;
      resp_q     <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      rdata_q    <= rdata_d;
      resp_q     <= resp_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      valid_q    <= valid_d;
    end
  end

  assign outdata_o = rdata_q;
  assign resp_o    = resp_q;
  assign valid_o   = valid_q;
  assign aw_addr   = addr_q;
  assign aw_valid  = aw_valid_q;
  assign w_data    = wdata_q;
  assign w_strb    = strb_q;
  assign w_valid   = w_valid_q;
  assign b_ready   = b_ready_q;
  assign ar_addr   = addr_q;
  assign ar_valid  = ar_valid_q;
  assign r_ready   = r_ready_q;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: an AXI-lite slave with programmable delays
// backed by its own memory, checked against a request-level memory model.
module tb_axi_lite_master_bridge;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 64;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [AW-1:0] address_i = '0;
  logic [DW-1:0] indata_i = '0;
  logic [SW-1:0] mask_i = '0;
  logic          ren_i = 1'b0, wen_i = 1'b0;
  logic [DW-1:0] outdata_o;
  logic [1:0]    resp_o;
  logic          valid_o;
  logic [AW-1:0] aw_addr, ar_addr;
  logic          aw_valid, w_valid, ar_valid, b_ready, r_ready;
  logic          aw_ready = 1'b0, w_ready = 1'b0, ar_ready = 1'b0;
  logic [DW-1:0] w_data;
  logic [SW-1:0] w_strb;
  logic [1:0]    b_resp = '0, r_resp = '0;
  logic          b_valid = 1'b0, r_valid = 1'b0;
  logic [DW-1:0] r_data = '0;

  always #5 clk = ~clk;

  axi_lite_master_bridge #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn),
    .address_i(address_i), .indata_i(indata_i), .mask_i(mask_i),
    .ren_i(ren_i), .wen_i(wen_i),
    .outdata_o(outdata_o), .resp_o(resp_o), .valid_o(valid_o),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Request-level reference memory and the slave's bus-level memory.
  logic [63:0] ref_mem [logic [63:0]];
  logic [63:0] slv_mem [logic [63:0]];
  logic [63:0] exp_out = '0;

  function automatic logic [63:0] init_word(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (m[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [63:0] slv_read(input logic [63:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_word(a);
  endfunction

  task automatic clear_slave();
    aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
    b_valid = 1'b0; b_resp = '0; r_valid = 1'b0; r_resp = '0; r_data = '0;
  endtask

  // Runs one transaction from a post-edge sample point. chained: the DUT is
  // in its completion cycle, so acceptance is one cycle later. keep: leave the
  // request asserted after valid_o.
  task automatic run_txn(input bit wr, input bit rd, input logic [63:0] addr,
                         input logic [63:0] data, input logic [7:0] mask,
                         input int aw_dly, input int w_dly, input int b_dly,
                         input int ar_dly, input int r_dly, input logic [1:0] rsp,
                         input bit chained, input bit keep);
    bit is_wr, zero, done;
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int aw_c, w_c, b_c, ar_c, r_c, k, off, ar_cycles;
    logic [63:0] cap_aw, cap_w, cap_ar;
    logic [7:0]  cap_s;
    is_wr = wr;
    zero  = (aw_dly == 0) && (w_dly == 0) && (b_dly == 0) && (ar_dly == 0) && (r_dly == 0);
    off   = chained ? 1 : 0;
    done = 0; aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0; k = 0; ar_cycles = 0;
    cap_aw = '0; cap_w = '0; cap_ar = '0; cap_s = '0;
    address_i = addr; indata_i = data; mask_i = mask; wen_i = wr; ren_i = rd;
    while (!done && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (k > off) begin
        if (is_wr) begin
          check("ar_unused", ar_valid, 0);
          check(aw_hs ? "aw_drop" : "aw_hold", aw_valid, aw_hs ? 1'b0 : 1'b1);
          check(w_hs ? "w_drop" : "w_hold", w_valid, w_hs ? 1'b0 : 1'b1);
          if (b_ready) check("b_after_aw_w", aw_hs && w_hs, 1);
        end else begin
          check("aw_unused", aw_valid | w_valid, 0);
          check(ar_hs ? "ar_drop" : "ar_hold", ar_valid, ar_hs ? 1'b0 : 1'b1);
          if (ar_valid) ar_cycles++;
          if (r_ready) check("r_after_ar", ar_hs, 1);
        end
      end
      if (valid_o) begin
        done = 1;
        check("resp_before_valid", is_wr ? b_hs : r_hs, 1);
        check("resp_o", resp_o, rsp);
        if (is_wr) ref_mem[addr] = merge(ref_read(addr), data, mask);
        else       exp_out = ref_read(addr);
        check("outdata_o", outdata_o, exp_out);
        if (zero) check("latency", k, 3 + off);
        if (!is_wr) check("ar_cycles", ar_cycles, ar_dly + 1);
        if (!keep) begin wen_i = 0; ren_i = 0; end
        clear_slave();
      end else begin
        aw_ready = aw_valid && (aw_c >= aw_dly); if (aw_valid) aw_c++;
        w_ready  = w_valid && (w_c >= w_dly);    if (w_valid) w_c++;
        ar_ready = ar_valid && (ar_c >= ar_dly); if (ar_valid) ar_c++;
        b_valid  = b_ready && (b_c >= b_dly);    if (b_ready) b_c++;
        b_resp   = b_valid ? rsp : 2'b00;
        r_valid  = r_ready && (r_c >= r_dly);    if (r_ready) r_c++;
        r_resp   = r_valid ? rsp : 2'b00;
        r_data   = r_valid ? slv_read(cap_ar) : '0;
        if (aw_valid && aw_ready) begin
          aw_hs = 1; cap_aw = aw_addr; check("aw_addr", aw_addr, addr);
        end
        if (w_valid && w_ready) begin
          w_hs = 1; cap_w = w_data; cap_s = w_strb;
          check("w_data", w_data, data); check("w_strb", w_strb, mask);
        end
        if (ar_valid && ar_ready) begin
          ar_hs = 1; cap_ar = ar_addr; check("ar_addr", ar_addr, addr);
        end
        if (b_valid && b_ready) begin
          b_hs = 1; slv_mem[cap_aw] = merge(slv_read(cap_aw), cap_w, cap_s);
        end
        if (r_valid && r_ready) r_hs = 1;
      end
    end
    if (!done) begin
      check("timeout", done, 1);
      wen_i = 0; ren_i = 0; clear_slave();
    end else if (!keep) begin
      @(posedge clk); #1;
      check("valid_pulse", valid_o, 0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_aw_valid"}, aw_valid, 0);
    check({tag, "_w_valid"},  w_valid, 0);
    check({tag, "_b_ready"},  b_ready, 0);
    check({tag, "_ar_valid"}, ar_valid, 0);
    check({tag, "_r_ready"},  r_ready, 0);
    check({tag, "_valid_o"},  valid_o, 0);
    check({tag, "_outdata"},  outdata_o, 0);
    check({tag, "_resp"},     resp_o, 0);
  endtask

  initial begin
    bit prev_keep, keep, wr, rd;
    logic [63:0] a;
    #12;
    check_idle_outputs("por");
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // Zero-wait write
    run_txn(1, 0, 64'h1000_0000, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    // Slow read of a freshly written word
    run_txn(1, 0, 64'h2000, 64'h1234, 8'hFF, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    run_txn(0, 1, 64'h2000, 64'h0, 8'h00, 0, 0, 0, 2, 2, 2'b00, 0, 0);
    check("read_0x1234", outdata_o, 64'h1234);
    // Skewed write channels, both orders, partial strobes
    run_txn(1, 0, 64'h3000, 64'h1111_2222_3333_4444, 8'h0F, 0, 4, 1, 0, 0, 2'b00, 0, 0);
    run_txn(1, 0, 64'h3000, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 4, 0, 0, 0, 0, 2'b00, 0, 0);
    check("write_keeps_out", outdata_o, 64'h1234);
    run_txn(0, 1, 64'h3000, 64'h0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    check("merged_word", outdata_o, 64'hAAAA_BBBB_3333_4444);
    // Simultaneous read and write requests: write wins
    run_txn(1, 1, 64'h8, 64'h0BAD_F00D_0000_0008, 8'hFF, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    // Error response, then a held back-to-back request
    run_txn(0, 1, 64'h8, 64'h0, 8'h00, 0, 0, 0, 0, 0, 2'b10, 0, 1);
    run_txn(0, 1, 64'h8, 64'h0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 1, 0);
    check("b2b_data", outdata_o, 64'h0BAD_F00D_0000_0008);

    // Reset while waiting for read data
    address_i = 64'h2000; ren_i = 1'b1; wen_i = 1'b0;
    for (int i = 0; i < 20 && !r_ready; i++) begin
      @(posedge clk); #1;
      ar_ready = ar_valid;
    end
    check("reached_rdata", r_ready, 1);
    #2 rstn = 1'b0;
    #1;
    check_idle_outputs("midrst");
    ren_i = 1'b0; clear_slave(); exp_out = '0;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    run_txn(0, 1, 64'h2000, 64'h0, 8'h00, 0, 0, 0, 0, 0, 2'b00, 0, 0);

    // Randomized traffic over a small address pool
    prev_keep = 0;
    for (int t = 0; t < 40; t++) begin
      a    = 64'h4000 + 64'($urandom_range(0, 7)) * 64'd8;
      wr   = $urandom_range(0, 1) == 1;
      rd   = !wr || ($urandom_range(0, 1) == 1);
      keep = (t != 39) && ($urandom_range(0, 3) == 0);
      run_txn(wr, rd, a, {$urandom, $urandom}, 8'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4),
              ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00, prev_keep, keep);
      prev_keep = keep;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
